seg7_scan_decoder: RTL

//  Receive side of the common-anode 7-segment display interface: snoops a

---
 rtl/seg7_scan_decoder.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/seg7_scan_decoder.sv
// Snoops a multiplexed common-anode 7-segment bus, qualifies each anode dwell
// for stability, decodes it back to BCD and hands whole frames out over valid/ready.
module seg7_scan_decoder #(
    parameter int NUM_DIGITS    = 4,
    parameter int STABLE_CYCLES = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [6:0]              seg,
    input  logic [NUM_DIGITS-1:0]   an,
    output logic [4*NUM_DIGITS-1:0] digits,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    seg_err,
    output logic                    overrun
);

    typedef enum logic [1:0] {S_WAIT, S_COUNT, S_DONE} state_t;

    localparam logic [8:0] STABLE_LIM = 9'(STABLE_CYCLES);

    state_t                  state, state_nxt;
    logic [6:0]              s_seg, ref_seg, ref_seg_nxt;
    logic [NUM_DIGITS-1:0]   s_an, ref_an, ref_an_nxt;
    logic [7:0]              cnt, cnt_nxt;
    logic [8:0]              cnt_inc;
    logic                    capture, reload, dwell, same;
    logic [3:0]              code;
    logic [NUM_DIGITS-1:0]   mask, mask_now;
    logic [4*NUM_DIGITS-1:0] slots, slots_now;
    logic                    complete, out_free;

    function automatic logic [3:0] decode(input logic [6:0] p);
        case (p)
            7'b0000001: decode = 4'd0;
            7'b1001111: decode = 4'd1;
            7'b0010010: decode = 4'd2;
            7'b0000110: decode = 4'd3;
            7'b1001100: decode = 4'd4;
            7'b0100100: decode = 4'd5;
            7'b0100000: decode = 4'd6;
            7'b0001111: decode = 4'd7;
            7'b0000000: decode = 4'd8;
            7'b0000100: decode = 4'd9;
            7'b1111111: decode = 4'hF;
            default:    decode = 4'hE;
        endcase
    endfunction

    // Dwell qualification: a dwell is exactly one anode low; any change restarts the count.
    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        ref_an_nxt  = ref_an;
        ref_seg_nxt = ref_seg;
        capture     = 1'b0;
        reload      = 1'b0;
        dwell       = $onehot(~s_an);
        same        = (s_an == ref_an) && (s_seg == ref_seg);
        cnt_inc     = {1'b0, cnt} + 9'd1;
        case (state)
            S_WAIT:  reload = 1'b1;
            S_COUNT: begin
                if (same) begin
                    cnt_nxt = cnt_inc[7:0];
                    if (cnt_inc == STABLE_LIM) begin
                        capture   = 1'b1;
                        state_nxt = S_DONE;
                    end
                end else begin
                    reload = 1'b1;
                end
            end
            S_DONE:  reload = !same;
            default: reload = 1'b1;
        endcase
        if (reload) begin
            if (dwell) begin
                cnt_nxt     = 8'd1;
                ref_an_nxt  = s_an;
                ref_seg_nxt = s_seg;
                if (STABLE_CYCLES == 1) begin
                    capture   = 1'b1;
                    state_nxt = S_DONE;
                end else begin
                    state_nxt = S_COUNT;
                end
            end else begin
                cnt_nxt   = '0;
                state_nxt = S_WAIT;
            end
        end
    end

    // Slot and mask views including this cycle's capture, so a frame can complete immediately.
    always_comb begin
        code      = decode(s_seg);
        slots_now = slots;
        mask_now  = mask;
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            if (capture && !s_an[i]) begin
                slots_now[4*i +: 4] = code;
                mask_now[i]         = 1'b1;
            end
        end
        complete = &mask_now;
        out_free = !out_valid || out_ready;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= S_WAIT;
            s_seg   <= '0;
            s_an    <= '0;
            ref_seg <= '0;
            ref_an  <= '0;
            cnt     <= '0;
        end else begin
            state   <= state_nxt;
            s_seg   <= seg;
            s_an    <= an;
            ref_seg <= ref_seg_nxt;
            ref_an  <= ref_an_nxt;
            cnt     <= cnt_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            slots     <= '0;
            mask      <= '0;
            digits    <= '0;
            out_valid <= 1'b0;
            seg_err   <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            slots   <= slots_now;
            seg_err <= capture && (code == 4'hE);
            overrun <= 1'b0;
            if (complete) begin
                mask <= '0;
                if (out_free) begin
                    digits    <= slots_now;
                    out_valid <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else begin
                mask <= mask_now;
                if (out_valid && out_ready) begin
                    out_valid <= 1'b0;
                end
            end
        end
    end

endmodule
